pkt_commit_fifo: RTL and testbench
==================================

Name: pkt_commit_fifo

Overview:
- Packet-aware FIFO with first-word fall-through. Write side is speculative: beats become visible to the reader only when the packet's last beat is accepted (commit).
- Writer can abort an in-flight packet. Packets larger than the FIFO are auto-dropped, never deadlocked.
- Sits between packet producers (MAC/DMA ingress) and per-core consumers. Replaces the plain single-word FIFO where partial or bad packets must never leak downstream.

Parameters:
- ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, payload width; memory word is DATA_WIDTH+1 (payload plus last flag).
- AF_THRESH, 4, almost_full asserts when free_count <= AF_THRESH.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as rst except din_ready is not forced low.
- din_valid  in  1  write beat valid.
- din  in  DATA_WIDTH  write payload.
- din_last  in  1  beat is the last of its packet (commit).
- din_abort  in  1  discard the current packet; qualified by an accepted beat.
- din_ready  out  1  write beat accepted when din_valid & din_ready.
- dout_valid  out  1  committed data available.
- dout  out  DATA_WIDTH  head payload.
- dout_last  out  1  head is a packet's last beat.
- dout_ready  in  1  read accept.
- item_count  out  ADDR_WIDTH+1  committed, unread entries.
- free_count  out  ADDR_WIDTH+1  DEPTH minus (speculative plus committed) occupancy.
- full  out  1  free_count == 0.
- empty  out  1  item_count == 0.
- almost_full  out  1  free_count <= AF_THRESH.
- drop_pulse  out  1  one-cycle pulse per dropped packet (abort or oversize).
- drop_count  out  CNT_WIDTH  saturating count of dropped packets.

Behaviour:
- Pointers are ADDR_WIDTH+1 bits (MSB is the wrap bit): rptr, wptr_com (committed), wptr_spec (speculative). Counts are modular differences.
  - item_count = wptr_com - rptr.
  - free_count = DEPTH - (wptr_spec - rptr).
- Reset or clear:
  - All pointers 0; state ACCEPT.
  - drop_pulse 0, dout_valid 0, empty 1, full 0.
  - drop_count 0 on rst only; clear preserves it.
  - din_ready 0 while rst is high.
- Read side:
  - dout/dout_last are asynchronous reads at rptr (zero latency). dout_valid = ~empty.
  - deque = dout_valid & dout_ready → rptr+1.
- Commit latency: the last beat is accepted in cycle N; dout_valid and item_count reflect the packet in N+1.
- State ACCEPT:
  - din_ready = ~full & ~rst.
  - Accepted beat with din_abort=1: beat not written; wptr_spec <= wptr_com; drop_pulse next cycle; state stays ACCEPT. Abort takes priority over din_last.
  - Accepted beat with din_last=1: write; wptr_com <= wptr_spec+1; wptr_spec <= wptr_spec+1.
  - Accepted non-last beat with (wptr_spec - wptr_com) == DEPTH-1 (oversize): beat not written; wptr_spec <= wptr_com; drop_pulse; state → DISCARD.
  - Other accepted beat: write at wptr_spec; wptr_spec+1.
- State DISCARD:
  - din_ready = ~rst; beats are consumed and not written.
  - Accepted beat with din_last or din_abort → ACCEPT. No second drop_pulse.
- A packet of exactly DEPTH beats is legal: full=1 after commit.
- Simultaneous commit and deque in the same cycle: both pointers update; item_count changes by (packet length - 1) net, with no lost updates.
- drop_count increments on each drop_pulse and saturates at all-ones.
- Invariants: rptr <= wptr_com <= wptr_spec (modular). Full and empty are never both 1.

Decomposition:
- Shared package/header: DEPTH localparam, state encoding (ACCEPT=0, DISCARD=1), pointer-difference helper function.
- One sub-module: pkt_fifo_mem, a DEPTH x (DATA_WIDTH+1) RAM with synchronous write and asynchronous read. Control stays in the top.

Test Plan:
All scenarios use ADDR_WIDTH=3 (DEPTH=8) and AF_THRESH=2.
1. Write 0xA, 0xB, 0xC (last on 0xC) with dout_ready=1 → dout_valid stays 0 through the cycle 0xC is accepted; next cycle dout=0xA; reads 0xA, 0xB, 0xC, with dout_last only on 0xC; item_count 3→2→1→0.
2. Write 0x1, 0x2, then 0x3 with din_abort=1 → no output ever; drop_pulse once; drop_count=1; free_count returns to 8.
3. 10-beat packet → 8th beat triggers DISCARD; din_ready stays 1 for beats 8–10; empty stays 1; drop_count=1. A following 2-beat packet 0x55, 0x66 reads out intact.
4. Exactly 8-beat packet, dout_ready=0 → after commit full=1, din_ready=0, almost_full=1, item_count=8. Drain → 8 beats in order, empty=1.
5. Continuous 3-beat packets with random dout_ready over 5 pointer wraps → exact order, no loss. Commit and deque in the same cycle verified: item_count 2 + commit 3 − 1 read = 4.
6. Assert clear mid-packet with 2 committed entries → next cycle empty=1, free_count=8, drop_count unchanged. Assert rst → din_ready=0 during reset, drop_count=0 after.

Source files
------------

// File: rtl/pkt_commit_fifo_pkg.sv
// Shared types and helpers for the packet-commit FIFO.
// The write-side FSM encoding and the wrap-aware pointer arithmetic live here.
package pkt_commit_fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
    localparam int unsigned DEPTH              = 2 ** ADDR_WIDTH_DEFAULT;

    typedef enum logic {
        StAccept  = 1'b0,
        StDiscard = 1'b1
    } state_e;

    // Modular difference of two pointers that are pw bits wide (wrap bit included).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned pw);
        logic [31:0] w_mask;
        w_mask = (32'd1 << pw) - 32'd1;
        return (a - b) & w_mask;
    endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Storage array for the packet FIFO: synchronous write port, asynchronous read port.
// No reset, so the array can map onto distributed RAM.
module pkt_fifo_mem #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned WIDTH      = 33
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pkt_commit_fifo.sv
// Packet-aware first-word-fall-through FIFO. Beats land speculatively and only become
// visible to the reader once the packet's last beat commits; aborted/oversize packets vanish.
module pkt_commit_fifo
    import pkt_commit_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned AF_THRESH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_din_valid,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_din_last,
    input  logic                  i_din_abort,
    output logic                  o_din_ready,
    output logic                  o_dout_valid,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_last,
    input  logic                  i_dout_ready,
    output logic [ADDR_WIDTH:0]   o_item_count,
    output logic [ADDR_WIDTH:0]   o_free_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_drop_pulse,
    output logic [CNT_WIDTH-1:0]  o_drop_count
);

    localparam int unsigned   PW         = ADDR_WIDTH + 1;
    localparam int unsigned   L_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [PW-1:0] DEPTH_P    = PW'(L_DEPTH);
    localparam logic [PW-1:0] OVERSIZE_P = PW'(L_DEPTH - 1);
    localparam logic [PW-1:0] ONE_P      = PW'(1);

    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_wptr_com;
    logic [PW-1:0]         r_wptr_spec;
    state_e                r_state;
    logic                  r_drop_pulse;
    logic [CNT_WIDTH-1:0]  r_drop_count;

    logic [PW-1:0]         w_rptr_next;
    logic [PW-1:0]         w_wptr_com_next;
    logic [PW-1:0]         w_wptr_spec_next;
    state_e                w_state_next;
    logic [PW-1:0]         w_item_count;
    logic [PW-1:0]         w_spec_occ;
    logic [PW-1:0]         w_pending;
    logic [PW-1:0]         w_free_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_din_ready;
    logic                  w_deque;
    logic                  w_we;
    logic                  w_mem_we;
    logic                  w_drop;
    logic [DATA_WIDTH:0]   w_rdata;

    assign w_item_count = PW'(ptr_diff(32'(r_wptr_com), 32'(r_rptr), PW));
    assign w_spec_occ   = PW'(ptr_diff(32'(r_wptr_spec), 32'(r_rptr), PW));
    assign w_pending    = PW'(ptr_diff(32'(r_wptr_spec), 32'(r_wptr_com), PW));
    assign w_free_count = DEPTH_P - w_spec_occ;
    assign w_full       = (w_free_count == '0);
    assign w_empty      = (w_item_count == '0);

    assign w_deque      = ~w_empty & i_dout_ready;
    assign w_rptr_next  = w_deque ? (r_rptr + ONE_P) : r_rptr;

    always_comb begin
        w_state_next     = r_state;
        w_wptr_spec_next = r_wptr_spec;
        w_wptr_com_next  = r_wptr_com;
        w_we             = 1'b0;
        w_drop           = 1'b0;
        w_din_ready      = 1'b0;
        case (r_state)
            StAccept: begin
                w_din_ready = ~w_full & ~i_rst;
                if (i_din_valid && w_din_ready) begin
                    if (i_din_abort) begin
                        w_wptr_spec_next = r_wptr_com;
                        w_drop           = 1'b1;
                    end else if (i_din_last) begin
                        w_we             = 1'b1;
                        w_wptr_spec_next = r_wptr_spec + ONE_P;
                        w_wptr_com_next  = r_wptr_spec + ONE_P;
                    end else if (w_pending == OVERSIZE_P) begin
                        // Packet cannot fit even in an empty FIFO: drop it and swallow the rest.
                        w_wptr_spec_next = r_wptr_com;
                        w_drop           = 1'b1;
                        w_state_next     = StDiscard;
                    end else begin
                        w_we             = 1'b1;
                        w_wptr_spec_next = r_wptr_spec + ONE_P;
                    end
                end
            end
            StDiscard: begin
                w_din_ready = ~i_rst;
                if (i_din_valid && w_din_ready && (i_din_last || i_din_abort)) begin
                    w_state_next = StAccept;
                end
            end
            default: begin
                w_state_next = StAccept;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_rptr       <= '0;
            r_wptr_com   <= '0;
            r_wptr_spec  <= '0;
            r_state      <= StAccept;
            r_drop_pulse <= 1'b0;
        end else begin
            r_rptr       <= w_rptr_next;
            r_wptr_com   <= w_wptr_com_next;
            r_wptr_spec  <= w_wptr_spec_next;
            r_state      <= w_state_next;
            r_drop_pulse <= w_drop;
        end
    end

    // The drop counter survives a flush; only a full reset zeroes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_count <= '0;
        end else if (!i_clear && w_drop && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
    end

    assign w_mem_we = w_we & ~i_rst & ~i_clear;

    pkt_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (DATA_WIDTH + 1)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wptr_spec[ADDR_WIDTH-1:0]),
        .i_wdata ({i_din_last, i_din}),
        .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rdata)
    );

    assign o_din_ready   = w_din_ready;
    assign o_dout_valid  = ~w_empty;
    assign o_dout        = w_rdata[DATA_WIDTH-1:0];
    assign o_dout_last   = w_rdata[DATA_WIDTH];
    assign o_item_count  = w_item_count;
    assign o_free_count  = w_free_count;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (32'(w_free_count) <= AF_THRESH);
    assign o_drop_pulse  = r_drop_pulse;
    assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Directed bench for pkt_commit_fifo with a committed-packet scoreboard.
// DEPTH=8, AF_THRESH=2; every cycle compares status outputs against the reference model.
module tb_pkt_commit_fifo;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned AFT   = 2;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst, clear, din_valid, din_last, din_abort, dout_ready;
    logic [DW-1:0] din, dout;
    logic          din_ready, dout_valid, dout_last, full, empty, almost_full, drop_pulse;
    logic [AW:0]   item_count, free_count;
    logic [CW-1:0] drop_count;

    always #5 clk = ~clk;

    pkt_commit_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .AF_THRESH  (AFT),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clear       (clear),
        .i_din_valid   (din_valid),
        .i_din         (din),
        .i_din_last    (din_last),
        .i_din_abort   (din_abort),
        .o_din_ready   (din_ready),
        .o_dout_valid  (dout_valid),
        .o_dout        (dout),
        .o_dout_last   (dout_last),
        .i_dout_ready  (dout_ready),
        .o_item_count  (item_count),
        .o_free_count  (free_count),
        .o_full        (full),
        .o_empty       (empty),
        .o_almost_full (almost_full),
        .o_drop_pulse  (drop_pulse),
        .o_drop_count  (drop_count)
    );

    int            n_vec  = 0;
    int            n_miss = 0;
    logic [DW:0]   sb[$];
    logic [DW:0]   pend[$];
    bit            m_discard  = 1'b0;
    bit            m_drop_exp = 1'b0;
    bit            rand_rd    = 1'b0;
    bit            last_acc   = 1'b0;
    logic [CW-1:0] m_drops    = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model, then advance the model past the coming edge.
    task automatic tick();
        int unsigned fexp;
        logic [DW:0] w;
        bit          drop_now;
        if (rand_rd) dout_ready = 1'($urandom_range(0, 1));
        #1;
        fexp = DEPTH - sb.size() - pend.size();
        chk("item_count", 64'(item_count), 64'(sb.size()));
        chk("free_count", 64'(free_count), 64'(fexp));
        chk("empty", 64'(empty), 64'(sb.size() == 0));
        chk("full", 64'(full), 64'(fexp == 0));
        chk("almost_full", 64'(almost_full), 64'(fexp <= AFT));
        chk("drop_pulse", 64'(drop_pulse), 64'(m_drop_exp));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
        chk("din_ready", 64'(din_ready), 64'(!rst && (m_discard || fexp != 0)));
        chk("dout_valid", 64'(dout_valid), 64'(sb.size() != 0));
        if (dout_valid && dout_ready && sb.size() != 0) begin
            w = sb.pop_front();
            chk("dout", 64'({dout_last, dout}), 64'(w));
        end
        last_acc = din_valid && din_ready;
        drop_now = 1'b0;
        if (rst || clear) begin
            sb.delete();
            pend.delete();
            m_discard = 1'b0;
            if (rst) m_drops = '0;
        end else if (last_acc) begin
            if (m_discard) begin
                if (din_last || din_abort) m_discard = 1'b0;
            end else if (din_abort) begin
                pend.delete();
                drop_now = 1'b1;
            end else if (din_last) begin
                pend.push_back({1'b1, din});
                while (pend.size() != 0) sb.push_back(pend.pop_front());
            end else if (pend.size() == DEPTH - 1) begin
                pend.delete();
                m_discard = 1'b1;
                drop_now  = 1'b1;
            end else begin
                pend.push_back({1'b0, din});
            end
        end
        m_drop_exp = drop_now;
        if (drop_now && m_drops != '1) m_drops++;
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit abort,
                             output int waited);
        din       = d;
        din_last  = last;
        din_abort = abort;
        din_valid = 1'b1;
        waited    = 0;
        do begin
            tick();
            waited++;
        end while (!last_acc && waited < 300);
        if (!last_acc) chk("accept_timeout", 64'(0), 64'(1));
        din_valid = 1'b0;
        din_last  = 1'b0;
        din_abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int w;
        rst = 1'b1; clear = 1'b0; din_valid = 1'b0; din = '0;
        din_last = 1'b0; din_abort = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: simple 3-beat packet, visible only after commit
        dout_ready = 1'b1;
        send_beat(32'hA, 1'b0, 1'b0, w);
        send_beat(32'hB, 1'b0, 1'b0, w);
        send_beat(32'hC, 1'b1, 1'b0, w);
        #1 chk("s1_head", 64'(dout), 64'(32'hA));
        repeat (4) tick();

        // 2: aborted packet never leaks
        send_beat(32'h1, 1'b0, 1'b0, w);
        send_beat(32'h2, 1'b0, 1'b0, w);
        send_beat(32'h3, 1'b0, 1'b1, w);
        repeat (3) tick();
        #1 chk("s2_drop_count", 64'(drop_count), 64'(1));
        chk("s2_free", 64'(free_count), 64'(8));
        tick();

        // 3: oversize packet auto-dropped, following packet intact
        for (int i = 1; i <= 10; i++) begin
            send_beat(32'h30 + 32'(i), (i == 10), 1'b0, w);
            if (i >= 8) chk("s3_ready_in_discard", 64'(w), 64'(1));
        end
        send_beat(32'h55, 1'b0, 1'b0, w);
        send_beat(32'h66, 1'b1, 1'b0, w);
        repeat (4) tick();
        #1 chk("s3_drop_count", 64'(drop_count), 64'(2));
        tick();

        // 4: exactly DEPTH beats fill the FIFO
        dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h400 + 32'(i), (i == 7), 1'b0, w);
        #1 chk("s4_full", 64'(full), 64'(1));
        chk("s4_din_ready", 64'(din_ready), 64'(0));
        chk("s4_almost_full", 64'(almost_full), 64'(1));
        chk("s4_item_count", 64'(item_count), 64'(8));
        tick();
        dout_ready = 1'b1;
        repeat (9) tick();
        #1 chk("s4_empty", 64'(empty), 64'(1));
        tick();

        // 5: commit and deque in the same cycle, then random-ready streaming
        dout_ready = 1'b0;
        send_beat(32'h100, 1'b0, 1'b0, w);
        send_beat(32'h101, 1'b1, 1'b0, w);
        send_beat(32'h102, 1'b0, 1'b0, w);
        send_beat(32'h103, 1'b0, 1'b0, w);
        dout_ready = 1'b1;
        send_beat(32'h104, 1'b1, 1'b0, w);
        dout_ready = 1'b0;
        #1 chk("s5_commit_deque", 64'(item_count), 64'(4));
        tick();
        rand_rd = 1'b1;
        for (int p = 0; p < 16; p++) begin
            for (int b = 0; b < 3; b++) send_beat(32'h1000 + 32'(p * 3 + b), (b == 2), 1'b0, w);
        end
        rand_rd    = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        tick();
        #1 chk("s5_drained", 64'(empty), 64'(1));
        tick();

        // 6: clear mid-packet keeps drop_count, reset zeroes it
        dout_ready = 1'b0;
        send_beat(32'h200, 1'b0, 1'b0, w);
        send_beat(32'h201, 1'b1, 1'b0, w);
        send_beat(32'h202, 1'b0, 1'b0, w);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1 chk("s6_clear_empty", 64'(empty), 64'(1));
        chk("s6_clear_free", 64'(free_count), 64'(8));
        chk("s6_clear_drops", 64'(drop_count), 64'(2));
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1 chk("s6_rst_drops", 64'(drop_count), 64'(0));
        tick();
        dout_ready = 1'b1;
        send_beat(32'h300, 1'b1, 1'b0, w);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
